// File: rtl/hybrid_pkg.sv
// Shared definitions for the hybrid drive scheduler: one-hot state encodings
// and default sizing for the battery/tank level counters.
package hybrid_pkg;

   localparam int unsigned BAT_MAX_DEF       = 20;
   localparam int unsigned TANQUE_MAX_DEF    = 15;
   localparam int unsigned BAT_UMBRAL_DEF    = 4;
   localparam int unsigned REGEN_DIV_DEF     = 4;
   localparam int unsigned CAMBIO_CICLOS_DEF = 2;
   localparam int unsigned ANCHO_DEF         = 8;

   typedef enum logic [4:0] {
      StReposo    = 5'b00001,
      StElectrico = 5'b00010,
      StGas       = 5'b00100,
      StCambio    = 5'b01000,
      StAgotado   = 5'b10000
   } estado_e;

endpackage

// File: rtl/nivel_contador.sv
// Saturating up/down level counter with synchronous full-load; an async reset
// also returns it to full.
module nivel_contador #(
   parameter int unsigned ANCHO = 8,
   parameter int unsigned MAX   = 20
) (
   input  logic             CLK,
   input  logic             REINICIO,
   input  logic             carga_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [ANCHO-1:0] nivel_o
);

   logic [ANCHO-1:0] nivel_q, nivel_d;

   // Load beats any same-edge count; simultaneous inc and dec cancel.
   always_comb begin
      nivel_d = nivel_q;
      if (carga_i) begin
         nivel_d = ANCHO'(MAX);
      end else if (inc_i && !dec_i) begin
         if (nivel_q < ANCHO'(MAX)) nivel_d = nivel_q + ANCHO'(1);
      end else if (dec_i && !inc_i) begin
         if (nivel_q != '0) nivel_d = nivel_q - ANCHO'(1);
      end
   end

   always_ff @(posedge CLK or negedge REINICIO) begin
      if (!REINICIO) nivel_q <= ANCHO'(MAX);
      else           nivel_q <= nivel_d;
   end

   assign nivel_o = nivel_q;

endmodule

// File: rtl/hybrid_drive_scheduler.sv
// Chooses between the electric and gas motors from battery/tank levels, with
// regeneration while on gas and a dead-time whenever the source changes.
module hybrid_drive_scheduler
   import hybrid_pkg::*;
#(
   parameter int unsigned BAT_MAX       = BAT_MAX_DEF,
   parameter int unsigned TANQUE_MAX    = TANQUE_MAX_DEF,
   parameter int unsigned BAT_UMBRAL    = BAT_UMBRAL_DEF,
   parameter int unsigned REGEN_DIV     = REGEN_DIV_DEF,
   parameter int unsigned CAMBIO_CICLOS = CAMBIO_CICLOS_DEF,
   parameter int unsigned ANCHO         = ANCHO_DEF
) (
   input  logic             CLK,
   input  logic             REINICIO,
   input  logic             ARRANQUE,
   input  logic             MODO,
   input  logic             RECARGA_BAT,
   input  logic             RECARGA_TANQUE,
   output logic             MOTOR1,
   output logic             MOTOR2,
   output logic [ANCHO-1:0] NIVEL_BAT,
   output logic [ANCHO-1:0] NIVEL_TANQUE,
   output logic             AGOTADO
);

   localparam int unsigned REGEN_W  = (REGEN_DIV > 2) ? $clog2(REGEN_DIV) : 1;
   localparam int unsigned CAMBIO_W = (CAMBIO_CICLOS > 2) ? $clog2(CAMBIO_CICLOS) : 1;

   estado_e             state_q, state_d;
   estado_e             destino_q, destino_d;
   logic [REGEN_W-1:0]  regen_q, regen_d;
   logic [CAMBIO_W-1:0] cambio_q, cambio_d;

   logic [ANCHO-1:0] bat, tanque, bat_post;
   logic             bat_inc, bat_dec, tanque_dec;

   nivel_contador #(
      .ANCHO (ANCHO),
      .MAX   (BAT_MAX)
   ) u_bat (
      .CLK      (CLK),
      .REINICIO (REINICIO),
      .carga_i  (RECARGA_BAT),
      .inc_i    (bat_inc),
      .dec_i    (bat_dec),
      .nivel_o  (bat)
   );

   nivel_contador #(
      .ANCHO (ANCHO),
      .MAX   (TANQUE_MAX)
   ) u_tanque (
      .CLK      (CLK),
      .REINICIO (REINICIO),
      .carga_i  (RECARGA_TANQUE),
      .inc_i    (1'b0),
      .dec_i    (tanque_dec),
      .nivel_o  (tanque)
   );

   always_comb begin
      state_d    = state_q;
      destino_d  = destino_q;
      cambio_d   = '0;
      regen_d    = '0;
      bat_inc    = 1'b0;
      bat_dec    = 1'b0;
      tanque_dec = 1'b0;
      bat_post   = bat;
      unique case (state_q)
         StReposo: begin
            if (ARRANQUE) begin
               if (!MODO && bat > ANCHO'(BAT_UMBRAL)) state_d = StElectrico;
               else if (tanque != '0)                 state_d = StGas;
               else if (bat != '0)                    state_d = StElectrico;
               else                                   state_d = StAgotado;
            end
         end
         StElectrico: begin
            bat_dec = 1'b1;
            if (!ARRANQUE) begin
               state_d = StReposo;
            end else if (bat <= ANCHO'(BAT_UMBRAL) && tanque != '0) begin
               state_d   = StCambio;
               destino_d = StGas;
            end else if (bat <= ANCHO'(1) && tanque == '0) begin
               state_d = StAgotado;
            end
         end
         StGas: begin
            tanque_dec = 1'b1;
            if (regen_q == REGEN_W'(REGEN_DIV - 1)) begin
               bat_inc = 1'b1;
               if (bat < ANCHO'(BAT_MAX)) bat_post = bat + ANCHO'(1);
            end else begin
               regen_d = regen_q + REGEN_W'(1);
            end
            // The empty-tank decision sees the battery after this edge's regen.
            if (!ARRANQUE) begin
               state_d = StReposo;
            end else if (tanque <= ANCHO'(1)) begin
               if (bat_post != '0) begin
                  state_d   = StCambio;
                  destino_d = StElectrico;
               end else begin
                  state_d = StAgotado;
               end
            end else if (!MODO && bat == ANCHO'(BAT_MAX)) begin
               state_d   = StCambio;
               destino_d = StElectrico;
            end
            if (state_d != StGas) regen_d = '0;
         end
         StCambio: begin
            if (!ARRANQUE) begin
               state_d = StReposo;
            end else if (cambio_q == CAMBIO_W'(CAMBIO_CICLOS - 1)) begin
               state_d = destino_q;
            end else begin
               cambio_d = cambio_q + CAMBIO_W'(1);
            end
         end
         StAgotado: begin
            if (RECARGA_BAT || RECARGA_TANQUE) state_d = StReposo;
         end
         default: state_d = StReposo;
      endcase
   end

   always_ff @(posedge CLK or negedge REINICIO) begin
      if (!REINICIO) begin
         state_q   <= StReposo;
         destino_q <= StElectrico;
         regen_q   <= '0;
         cambio_q  <= '0;
      end else begin
         state_q   <= state_d;
         destino_q <= destino_d;
         regen_q   <= regen_d;
         cambio_q  <= cambio_d;
      end
   end

   always_comb begin
      MOTOR1  = 1'b0;
      MOTOR2  = 1'b0;
      AGOTADO = 1'b0;
      unique case (state_q)
         StElectrico: MOTOR1 = 1'b1;
         StGas:       MOTOR2 = 1'b1;
         StAgotado: begin
            MOTOR1  = 1'b1;
            MOTOR2  = 1'b1;
            AGOTADO = 1'b1;
         end
         default: ;
      endcase
   end

   assign NIVEL_BAT    = bat;
   assign NIVEL_TANQUE = tanque;

endmodule

// File: tb/tb_hybrid_drive_scheduler.sv
// Self-checking bench for hybrid_drive_scheduler: directed scenarios plus a
// randomized run, all checked against a behavioural vehicle model.
module tb_hybrid_drive_scheduler;

   localparam int BMAX = 20;
   localparam int TMAX = 15;
   localparam int UMB  = 4;
   localparam int RDIV = 4;
   localparam int DEAD = 2;

   // Model modes
   localparam int M_REP = 0;
   localparam int M_ELE = 1;
   localparam int M_GAS = 2;
   localparam int M_CAM = 3;
   localparam int M_AGO = 4;

   logic       CLK = 1'b0;
   logic       REINICIO = 1'b0;
   logic       ARRANQUE = 1'b0;
   logic       MODO = 1'b0;
   logic       RECARGA_BAT = 1'b0;
   logic       RECARGA_TANQUE = 1'b0;
   logic       MOTOR1, MOTOR2, AGOTADO;
   logic [7:0] NIVEL_BAT, NIVEL_TANQUE;

   int vectors = 0;
   int miscompares = 0;

   int m_mode, m_bat, m_tq, m_gas_cnt, m_dead, m_tgt;

   always #5 CLK = ~CLK;

   hybrid_drive_scheduler dut (
      .CLK            (CLK),
      .REINICIO       (REINICIO),
      .ARRANQUE       (ARRANQUE),
      .MODO           (MODO),
      .RECARGA_BAT    (RECARGA_BAT),
      .RECARGA_TANQUE (RECARGA_TANQUE),
      .MOTOR1         (MOTOR1),
      .MOTOR2         (MOTOR2),
      .NIVEL_BAT      (NIVEL_BAT),
      .NIVEL_TANQUE   (NIVEL_TANQUE),
      .AGOTADO        (AGOTADO)
   );

   task automatic model_reset();
      m_mode = M_REP; m_bat = BMAX; m_tq = TMAX;
      m_gas_cnt = 0; m_dead = 0; m_tgt = M_ELE;
   endtask

   // One clock edge of the vehicle, using levels as they were before the edge.
   task automatic model_edge(input bit arr, input bit modo, input bit rb, input bit rt);
      int nm, nb, nt, ng, nd;
      nm = m_mode; nb = m_bat; nt = m_tq; ng = 0; nd = 0;
      if (m_mode == M_REP) begin
         if (arr) begin
            if (!modo && m_bat > UMB) nm = M_ELE;
            else if (m_tq > 0)        nm = M_GAS;
            else if (m_bat > 0)       nm = M_ELE;
            else                      nm = M_AGO;
         end
      end else if (m_mode == M_ELE) begin
         nb = (m_bat > 0) ? m_bat - 1 : 0;
         if (!arr) nm = M_REP;
         else if (m_bat <= UMB && m_tq > 0) begin nm = M_CAM; m_tgt = M_GAS; end
         else if (m_bat <= 1 && m_tq == 0) nm = M_AGO;
      end else if (m_mode == M_GAS) begin
         nt = (m_tq > 0) ? m_tq - 1 : 0;
         ng = (m_gas_cnt + 1) % RDIV;
         if (ng == 0 && m_bat < BMAX) nb = m_bat + 1;
         if (!arr) nm = M_REP;
         else if (m_tq <= 1) begin
            if (nb > 0) begin nm = M_CAM; m_tgt = M_ELE; end
            else nm = M_AGO;
         end else if (!modo && m_bat == BMAX) begin nm = M_CAM; m_tgt = M_ELE; end
         if (nm != M_GAS) ng = 0;
      end else if (m_mode == M_CAM) begin
         if (!arr) nm = M_REP;
         else if (m_dead + 1 >= DEAD) nm = m_tgt;
         else nd = m_dead + 1;
      end else begin
         if (rb || rt) nm = M_REP;
      end
      if (rb) nb = BMAX;
      if (rt) nt = TMAX;
      m_mode = nm; m_bat = nb; m_tq = nt; m_gas_cnt = ng; m_dead = nd;
   endtask

   function automatic logic [18:0] model_out();
      logic m1, m2, ag;
      m1 = (m_mode == M_ELE) || (m_mode == M_AGO);
      m2 = (m_mode == M_GAS) || (m_mode == M_AGO);
      ag = (m_mode == M_AGO);
      return {m1, m2, ag, 8'(m_bat), 8'(m_tq)};
   endfunction

   task automatic drive_edge(input bit arr, input bit modo, input bit rb, input bit rt);
      ARRANQUE = arr; MODO = modo; RECARGA_BAT = rb; RECARGA_TANQUE = rt;
      @(posedge CLK);
      model_edge(arr, modo, rb, rt);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      ARRANQUE = 1'b0; RECARGA_BAT = 1'b0; RECARGA_TANQUE = 1'b0;
      REINICIO = 1'b0;
      #1;
      REINICIO = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [18:0] obs;
      @(negedge CLK);
      obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
      vectors++;
      if (obs !== {3'b000, 8'd20, 8'd15}) begin
         miscompares++;
         $display("FAIL reset_initial: got mot/ag=%b bat=%0d tq=%0d, want 000 20 15",
                  obs[18:16], obs[15:8], obs[7:0]);
      end
      #1 REINICIO = 1'b1;
      model_reset();
      drive_edge(1, 0, 0, 0);
      drive_edge(1, 0, 0, 0);
      vectors++;
      if (MOTOR1 !== 1'b1 || NIVEL_BAT !== 8'd19) begin
         miscompares++;
         $display("FAIL reset_pre_electric: got m1=%b bat=%0d, want 1 19", MOTOR1, NIVEL_BAT);
      end
      #2 REINICIO = 1'b0;
      #1;
      obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
      vectors++;
      if (obs !== {3'b000, 8'd20, 8'd15}) begin
         miscompares++;
         $display("FAIL reset_async: got mot/ag=%b bat=%0d tq=%0d, want 000 20 15",
                  obs[18:16], obs[15:8], obs[7:0]);
      end
      ARRANQUE = 1'b0;
      #1 REINICIO = 1'b1;
      model_reset();
      @(posedge CLK);
      model_edge(0, 0, 0, 0);
      @(negedge CLK);
      obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
      vectors++;
      if (obs !== model_out()) begin
         miscompares++;
         $display("FAIL reset_idle: got %b bat=%0d tq=%0d, want %b bat=%0d tq=%0d",
                  obs[18:16], obs[15:8], obs[7:0], model_out()[18:16], model_out()[15:8],
                  model_out()[7:0]);
      end
   endtask

   task automatic test_full_cycle();
      logic [1:0]  trace[$];
      logic [1:0]  want[$];
      logic [18:0] obs, exp;
      bit          done;
      do_reset();
      for (int i = 0; i < 17; i++) want.push_back(2'b10);
      for (int i = 0; i < 2; i++)  want.push_back(2'b00);
      for (int i = 0; i < 15; i++) want.push_back(2'b01);
      for (int i = 0; i < 2; i++)  want.push_back(2'b00);
      for (int i = 0; i < 6; i++)  want.push_back(2'b10);
      want.push_back(2'b11);
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         drive_edge(1, 0, 0, 0);
         obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
         exp = model_out();
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL full_cycle[%0d]: got %b bat=%0d tq=%0d, want %b bat=%0d tq=%0d",
                     i, obs[18:16], obs[15:8], obs[7:0], exp[18:16], exp[15:8], exp[7:0]);
         end
         trace.push_back({MOTOR1, MOTOR2});
         if (AGOTADO === 1'b1) done = 1;
      end
      vectors++;
      if (!done || trace.size() != want.size()) begin
         miscompares++;
         $display("FAIL full_cycle_length: got %0d cycles (exhausted=%0d), want %0d",
                  trace.size(), done, want.size());
      end
      for (int i = 0; i < trace.size() && i < want.size(); i++) begin
         vectors++;
         if (trace[i] !== want[i]) begin
            miscompares++;
            $display("FAIL full_cycle_profile[%0d]: got motors %b, want %b", i, trace[i], want[i]);
         end
      end
   endtask

   task automatic test_recharge_agotado();
      for (int i = 0; i < 3; i++) begin
         drive_edge(1, 0, 0, 0);
         vectors++;
         if (AGOTADO !== 1'b1 || NIVEL_BAT !== 8'd0 || {MOTOR1, MOTOR2} !== 2'b11) begin
            miscompares++;
            $display("FAIL agotado_hold[%0d]: got ag=%b bat=%0d mot=%b, want 1 0 11",
                     i, AGOTADO, NIVEL_BAT, {MOTOR1, MOTOR2});
         end
      end
      drive_edge(1, 0, 1, 0);
      vectors++;
      if (AGOTADO !== 1'b0 || NIVEL_BAT !== 8'd20 || {MOTOR1, MOTOR2} !== 2'b00) begin
         miscompares++;
         $display("FAIL agotado_recharge: got ag=%b bat=%0d mot=%b, want 0 20 00",
                  AGOTADO, NIVEL_BAT, {MOTOR1, MOTOR2});
      end
      drive_edge(1, 0, 0, 0);
      vectors++;
      if ({MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE} !== model_out()) begin
         miscompares++;
         $display("FAIL agotado_restart: got mot=%b bat=%0d, want %b bat=%0d",
                  {MOTOR1, MOTOR2}, NIVEL_BAT, model_out()[18:17], model_out()[15:8]);
      end
   endtask

   task automatic test_gas_first();
      logic [18:0] obs, exp;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         drive_edge(1, 1, 0, 0);
         obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
         exp = model_out();
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL gas_first[%0d]: got %b bat=%0d tq=%0d, want %b bat=%0d tq=%0d",
                     i, obs[18:16], obs[15:8], obs[7:0], exp[18:16], exp[15:8], exp[7:0]);
         end
         if (i < 15 || i == 15 || i == 16 || i == 17) begin
            vectors++;
            if ({MOTOR1, MOTOR2} !== ((i < 15) ? 2'b01 : (i < 17) ? 2'b00 : 2'b10) ||
                NIVEL_BAT !== 8'd20) begin
               miscompares++;
               $display("FAIL gas_first_profile[%0d]: got mot=%b bat=%0d", i,
                        {MOTOR1, MOTOR2}, NIVEL_BAT);
            end
         end
      end
   endtask

   task automatic test_stop();
      bit reached;
      do_reset();
      drive_edge(1, 0, 0, 0);
      reached = 0;
      for (int i = 0; i < 30 && !reached; i++) begin
         if (NIVEL_BAT === 8'd10) reached = 1;
         else drive_edge(1, 0, 0, 0);
      end
      vectors++;
      if (!reached || MOTOR1 !== 1'b1) begin
         miscompares++;
         $display("FAIL stop_reach: got bat=%0d m1=%b, want 10 1", NIVEL_BAT, MOTOR1);
      end
      for (int i = 0; i < 4; i++) begin
         drive_edge(0, 0, 0, 0);
         vectors++;
         if ({MOTOR1, MOTOR2, AGOTADO} !== 3'b000 || NIVEL_BAT !== 8'd9) begin
            miscompares++;
            $display("FAIL stop_hold[%0d]: got mot/ag=%b bat=%0d, want 000 9",
                     i, {MOTOR1, MOTOR2, AGOTADO}, NIVEL_BAT);
         end
      end
   endtask

   task automatic test_refuel_same_edge();
      bit reached;
      do_reset();
      drive_edge(1, 1, 0, 0);
      reached = 0;
      for (int i = 0; i < 30 && !reached; i++) begin
         if (NIVEL_TANQUE === 8'd7) reached = 1;
         else drive_edge(1, 1, 0, 0);
      end
      vectors++;
      if (!reached || MOTOR2 !== 1'b1) begin
         miscompares++;
         $display("FAIL refuel_reach: got tq=%0d m2=%b, want 7 1", NIVEL_TANQUE, MOTOR2);
      end
      drive_edge(1, 1, 0, 1);
      vectors++;
      if (NIVEL_TANQUE !== 8'd15 || MOTOR2 !== 1'b1) begin
         miscompares++;
         $display("FAIL refuel_same_edge: got tq=%0d m2=%b, want 15 1", NIVEL_TANQUE, MOTOR2);
      end
   endtask

   task automatic test_random();
      logic [18:0] obs, exp;
      bit arr, modo, rb, rt;
      do_reset();
      modo = 0;
      for (int i = 0; i < 1500; i++) begin
         arr  = ($urandom_range(0, 99) < 92);
         if ($urandom_range(0, 99) < 5) modo = ~modo;
         rb   = ($urandom_range(0, 99) < 2);
         rt   = ($urandom_range(0, 99) < 2);
         drive_edge(arr, modo, rb, rt);
         obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
         exp = model_out();
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL random[%0d]: got %b bat=%0d tq=%0d, want %b bat=%0d tq=%0d",
                     i, obs[18:16], obs[15:8], obs[7:0], exp[18:16], exp[15:8], exp[7:0]);
         end
         if ($urandom_range(0, 199) == 0) begin
            ARRANQUE = 1'b0;
            REINICIO = 1'b0;
            #1;
            obs = {MOTOR1, MOTOR2, AGOTADO, NIVEL_BAT, NIVEL_TANQUE};
            vectors++;
            if (obs !== {3'b000, 8'd20, 8'd15}) begin
               miscompares++;
               $display("FAIL random_reset[%0d]: got %b bat=%0d tq=%0d, want 000 20 15",
                        i, obs[18:16], obs[15:8], obs[7:0]);
            end
            #1 REINICIO = 1'b1;
            model_reset();
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_cycle();
      test_recharge_agotado();
      test_gas_first();
      test_stop();
      test_refuel_same_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
